// File: rtl/boot_loader.sv
// boot_loader: streams a byte image into the datapath RAM over MOV/MOC and holds the CPU in clear until done.
// Define BOOT_LOADER_VERIFY_EN to add a checksum readback pass after the last write.
module boot_loader #(
    parameter int ADDR_W      = 9,
    parameter int BASE_ADDR   = 0,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Clear_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_mov,
    output logic              mem_rw,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_moc,
    output logic              cpu_clear,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   byte_count
);

    // state       | meaning
    // IDLE        | after reset, waiting for start
    // ACCEPT      | in_ready high, waiting for a source byte
    // WRITE       | MOV held with write data until MOC or timeout
    // VERIFY_RD   | set up the next readback (verify build only)
    // VERIFY_WAIT | MOV held for a read until MOC or timeout
    // DONE        | load finished; CPU released only when error is clear
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
`ifdef BOOT_LOADER_VERIFY_EN
        S_VERIFY_RD,
        S_VERIFY_WAIT,
`endif
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [7:0]        TIMEOUT  = 8'(MOC_TIMEOUT);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        wdata_nxt;
    logic              last_q, last_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              error_nxt;
    logic [1:0]        code_nxt;
    logic [7:0]        csum, csum_nxt;
    logic [7:0]        wait_cnt, wait_nxt;

`ifdef BOOT_LOADER_VERIFY_EN
    logic [7:0]        rd_csum, rd_csum_nxt, rd_sum;
    logic [ADDR_W-1:0] end_addr, end_addr_nxt;
`else
    logic [7:0]        unused_rdata;
    assign unused_rdata = mem_rdata;
`endif

    assign done      = (state == S_DONE);
    assign cpu_clear = !(done && !error);

    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        last_nxt  = last_q;
        count_nxt = byte_count;
        error_nxt = error;
        code_nxt  = err_code;
        csum_nxt  = csum;
        wait_nxt  = wait_cnt;
        in_ready  = 1'b0;
        mem_mov   = 1'b0;
        mem_rw    = 1'b0;
`ifdef BOOT_LOADER_VERIFY_EN
        rd_csum_nxt  = rd_csum;
        end_addr_nxt = end_addr;
        rd_sum       = rd_csum + mem_rdata;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_ACCEPT;
                    error_nxt = 1'b0;
                    code_nxt  = 2'd0;
                    count_nxt = '0;
                    csum_nxt  = 8'd0;
                    addr_nxt  = BASE;
                end
            end
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wdata_nxt = in_data;
                    last_nxt  = in_last;
                    csum_nxt  = csum + in_data;
                    wait_nxt  = TIMEOUT;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_mov = 1'b1;
                if (mem_moc) begin
                    count_nxt = byte_count + CNT_ONE;
                    if (last_q) begin
`ifdef BOOT_LOADER_VERIFY_EN
                        state_nxt    = S_VERIFY_RD;
                        end_addr_nxt = mem_addr;
                        addr_nxt     = BASE;
                        rd_csum_nxt  = 8'd0;
`else
                        state_nxt = S_DONE;
`endif
                    end else if (mem_addr == '1) begin
                        // non-last byte landed on the top address: image too big, never wrap
                        state_nxt = S_DONE;
                        error_nxt = 1'b1;
                        code_nxt  = 2'd1;
                    end else begin
                        addr_nxt  = mem_addr + ADDR_ONE;
                        state_nxt = S_ACCEPT;
                    end
                end else if (wait_cnt == 8'd1) begin
                    state_nxt = S_DONE;
                    error_nxt = 1'b1;
                    code_nxt  = 2'd2;
                end else begin
                    wait_nxt = wait_cnt - 8'd1;
                end
            end
`ifdef BOOT_LOADER_VERIFY_EN
            S_VERIFY_RD: begin
                wait_nxt  = TIMEOUT;
                state_nxt = S_VERIFY_WAIT;
            end
            S_VERIFY_WAIT: begin
                mem_mov = 1'b1;
                mem_rw  = 1'b1;
                if (mem_moc) begin
                    rd_csum_nxt = rd_sum;
                    if (mem_addr == end_addr) begin
                        state_nxt = S_DONE;
                        if (rd_sum != csum) begin
                            error_nxt = 1'b1;
                            code_nxt  = 2'd3;
                        end
                    end else begin
                        addr_nxt  = mem_addr + ADDR_ONE;
                        state_nxt = S_VERIFY_RD;
                    end
                end else if (wait_cnt == 8'd1) begin
                    state_nxt = S_DONE;
                    error_nxt = 1'b1;
                    code_nxt  = 2'd2;
                end else begin
                    wait_nxt = wait_cnt - 8'd1;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state      <= S_IDLE;
            mem_addr   <= BASE;
            mem_wdata  <= 8'd0;
            last_q     <= 1'b0;
            byte_count <= '0;
            error      <= 1'b0;
            err_code   <= 2'd0;
            csum       <= 8'd0;
            wait_cnt   <= TIMEOUT;
`ifdef BOOT_LOADER_VERIFY_EN
            rd_csum    <= 8'd0;
            end_addr   <= BASE;
`endif
        end else begin
            state      <= state_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            last_q     <= last_nxt;
            byte_count <= count_nxt;
            error      <= error_nxt;
            err_code   <= code_nxt;
            csum       <= csum_nxt;
            wait_cnt   <= wait_nxt;
`ifdef BOOT_LOADER_VERIFY_EN
            rd_csum    <= rd_csum_nxt;
            end_addr   <= end_addr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed checks of boot_loader with a zero-wait RAM model (default DUT) and a 4-byte RAM (ADDR_W=2 DUT).
module tb_boot_loader;

    logic       Clk;
    logic       Clear_n;
    logic       start, s_start;
    logic       in_valid, in_last;
    logic [7:0] in_data;

    logic       in_ready, mem_mov, mem_rw, mem_moc, cpu_clear, done, error;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [1:0] err_code;
    logic [9:0] byte_count;

    logic       s_in_ready, s_mem_mov, s_mem_rw, s_mem_moc, s_cpu_clear, s_done, s_error;
    logic [1:0] s_mem_addr;
    logic [7:0] s_mem_wdata;
    logic [1:0] s_err_code;
    logic [2:0] s_byte_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [0:511];
    logic [7:0] small_ram [0:3];
    int op_count, hold_at, corrupt_at;

    boot_loader u_dut (
        .Clk(Clk), .Clear_n(Clear_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mov(mem_mov), .mem_rw(mem_rw),
        .mem_rdata(mem_rdata), .mem_moc(mem_moc),
        .cpu_clear(cpu_clear), .done(done), .error(error), .err_code(err_code),
        .byte_count(byte_count)
    );

    boot_loader #(.ADDR_W(2)) u_small (
        .Clk(Clk), .Clear_n(Clear_n), .start(s_start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(s_in_ready),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_mov(s_mem_mov), .mem_rw(s_mem_rw),
        .mem_rdata(8'h00), .mem_moc(s_mem_moc),
        .cpu_clear(s_cpu_clear), .done(s_done), .error(s_error), .err_code(s_err_code),
        .byte_count(s_byte_count)
    );

    always #5 Clk = ~Clk;

    // RAM answers a request on the first negedge it sees MOV; hold_at withholds one operation
    always @(negedge Clk) begin
        if (mem_moc) begin
            mem_moc = 1'b0;
        end else if (mem_mov && op_count != hold_at) begin
            mem_moc = 1'b1;
            if (mem_rw)
                mem_rdata = ram[mem_addr] ^ ((int'(mem_addr) == corrupt_at) ? 8'hFF : 8'h00);
            else
                ram[mem_addr] = mem_wdata;
            op_count++;
        end
    end

    always @(negedge Clk) begin
        if (s_mem_moc) begin
            s_mem_moc = 1'b0;
        end else if (s_mem_mov) begin
            s_mem_moc = 1'b1;
            small_ram[s_mem_addr] = s_mem_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) s_start = 1'b1;
        else     start   = 1'b1;
        @(negedge Clk);
        start   = 1'b0;
        s_start = 1'b0;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!(sel ? s_in_ready : in_ready) && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check_val("accept_wait", 32'(n < 50), 1);
        @(negedge Clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int n = 0;
        while (!(sel ? s_done : done) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check_val("done_wait", 32'(n < 200), 1);
    endtask

    initial begin
        logic [7:0] img [0:3];
        int cyc;
        img[0] = 8'h8C; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h10;
        Clk = 1'b0; Clear_n = 1'b0; start = 1'b0; s_start = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        mem_moc = 1'b0; mem_rdata = 8'h00; s_mem_moc = 1'b0;
        op_count = 0; hold_at = -1; corrupt_at = -1;
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        for (int i = 0; i < 4; i++) small_ram[i] = 8'h00;

        repeat (2) @(negedge Clk);
        check_val("rst_cpu_clear", cpu_clear, 1);
        check_val("rst_done", done, 0);
        check_val("rst_mov", mem_mov, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_ready", in_ready, 0);
        check_val("rst_count", byte_count, 0);
        check_val("rst_code", err_code, 0);
        Clear_n = 1'b1;
        @(negedge Clk);

        // 4-byte image, zero-wait RAM
        pulse_start(0);
        for (int i = 0; i < 4; i++) send_byte(0, img[i], i == 3);
`ifdef BOOT_LOADER_VERIFY_EN
        wait_done(0);
`else
        @(negedge Clk);
`endif
        check_val("load_done", done, 1);
        check_val("load_cpu_clear", cpu_clear, 0);
        check_val("load_error", error, 0);
        check_val("load_code", err_code, 0);
        check_val("load_count", byte_count, 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("load_ram%0d", i), ram[i], img[i]);

        // MOC withheld on the 2nd write
        hold_at = op_count + 1;
        pulse_start(0);
        check_val("restart_count", byte_count, 0);
        check_val("restart_done", done, 0);
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        check_val("to_mov_up", mem_mov, 1);
        cyc = 0;
        while (err_code != 2'd2 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        check_val("to_cycles", cyc, 15);
        check_val("to_mov_down", mem_mov, 0);
        check_val("to_done", done, 1);
        check_val("to_cpu_clear", cpu_clear, 1);
        check_val("to_count", byte_count, 1);
        hold_at = -1;

        // ADDR_W=2 overflow: 5 bytes, none last
        pulse_start(1);
        for (int i = 0; i < 4; i++) send_byte(1, 8'hA0 + 8'(i), 0);
        @(negedge Clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge Clk);
        check_val("ovf_ready", s_in_ready, 0);
        in_valid = 1'b0;
        check_val("ovf_done", s_done, 1);
        check_val("ovf_code", s_err_code, 1);
        check_val("ovf_error", s_error, 1);
        check_val("ovf_cpu_clear", s_cpu_clear, 1);
        check_val("ovf_addr", s_mem_addr, 3);
        check_val("ovf_count", s_byte_count, 4);
        check_val("ovf_ram0", small_ram[0], 8'hA0);
        check_val("ovf_ram3", small_ram[3], 8'hA3);

        // Clear_n dropped mid-WRITE, then a fresh 1-byte load
        ram[0] = 8'h00;
        hold_at = op_count;
        pulse_start(0);
        send_byte(0, 8'h5A, 0);
        repeat (3) @(negedge Clk);
        check_val("rst_mid_mov", mem_mov, 1);
        Clear_n = 1'b0;
        #1;
        check_val("rst_mid_mov0", mem_mov, 0);
        check_val("rst_mid_cpu", cpu_clear, 1);
        check_val("rst_mid_count", byte_count, 0);
        check_val("rst_mid_addr", mem_addr, 0);
        @(negedge Clk);
        Clear_n = 1'b1;
        hold_at = -1;
        @(negedge Clk);
        pulse_start(0);
        send_byte(0, 8'hA7, 1);
        wait_done(0);
        check_val("reload_count", byte_count, 1);
        check_val("reload_ram0", ram[0], 8'hA7);
        check_val("reload_ram1", ram[1], 8'h01);
        check_val("reload_error", error, 0);
        check_val("reload_cpu", cpu_clear, 0);

`ifdef BOOT_LOADER_VERIFY_EN
        corrupt_at = 2;
        pulse_start(0);
        for (int i = 0; i < 4; i++) send_byte(0, img[i], i == 3);
        wait_done(0);
        check_val("vfy_code", err_code, 3);
        check_val("vfy_error", error, 1);
        check_val("vfy_cpu_clear", cpu_clear, 1);
        corrupt_at = -1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
